// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake, operands and result flags of the serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  ready, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output ready, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_adder_unit_fa_cell.sv
// Single-bit combinational full adder used as the serial datapath cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_unit.sv
// Bit-serial adder/subtractor: LSB-first, one full-adder cell and a carry flop,
// WIDTH clocks per operation with a start/done handshake.
module serial_adder_unit
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q;
  state_e           state_d;
  logic             accept_c;
  logic             last_c;

  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-2:0] r_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;

  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             bit_c;
  logic             co_c;
  logic [WIDTH-1:0] r_next_c;

  fa_cell u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (bit_c),
    .co  (co_c)
  );

  // Result bits enter at the MSB so the final shift leaves the sum aligned.
  assign r_next_c = {bit_c, r_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          last_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_c) begin
        a_sh_q  <= bus.a;
        b_sh_q  <= bus.sub ? ~bus.b : bus.b;
        carry_q <= bus.sub;
        cnt_q   <= '0;
        ready_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
        a_sh_q  <= a_sh_q >> 1;
        b_sh_q  <= b_sh_q >> 1;
        r_q     <= r_next_c[WIDTH-1:1];
        carry_q <= co_c;
        cnt_q   <= cnt_q + CNT_W'(1);
        if (last_c) begin
          // carry_q here is still the carry into the MSB.
          sum_q   <= r_next_c;
          cout_q  <= co_c;
          ovf_q   <= carry_q ^ co_c;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule
